// File: rtl/arp_requester.sv
// ARP initiator: writes a broadcast ARP request into the TX buffer, then scans RX
// packets for the matching reply, with per-attempt timeout and bounded retries.
module arp_requester #(
  parameter int unsigned TIMEOUT_CYCLES = 12500000,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic        mac_clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] target_ip,
  input  logic [47:0] myMAC,
  input  logic [31:0] myIP,
  output logic        busy,
  output logic [47:0] resolved_mac,
  output logic        resolved_valid,
  output logic        fail,
  input  logic        packet_ready,
  output logic [5:0]  packet_read_addr,
  input  logic [7:0]  packet_data,
  output logic        done_with_packet,
  output logic [7:0]  packet_out,
  output logic [5:0]  packet_out_addr,
  output logic        packet_out_we,
  output logic        packet_xmit
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned AW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [AW-1:0] LAST_TRY = AW'(MAX_RETRIES);

  typedef enum logic [3:0] {
    IDLE, TX_WE, TX_NEXT, TX_XMIT, WAIT_REPLY, RX_SET, RX_WAIT1, RX_WAIT2,
    RX_CHECK, RX_DONE, RX_RELEASE, RETRY, RESOLVE, FAILED
  } state_t;

  state_t          state, next_state;
  logic [31:0]     tip;
  logic [AW-1:0]   attempt;
  logic [CW-1:0]   cnt;
  logic [5:0]      tx_addr, rx_addr, rx_next;
  logic [47:0]     shadow, mac_q;
  logic            match;
  logic            expired, more_tries, counting, capture, scan_end;
  logic [335:0]    frame;
  logic [8:0]      tx_bit;
  logic [7:0]      tx_byte, rx_ref;

  assign expired    = (cnt == LAST_CNT);
  assign more_tries = (attempt < LAST_TRY);
  assign counting   = (state inside {WAIT_REPLY, RX_SET, RX_WAIT1, RX_WAIT2,
                                     RX_CHECK, RX_DONE, RX_RELEASE});

  // Whole request frame as one vector, byte 0 in the top bits.
  always_comb begin
    frame   = {{6{8'hFF}}, myMAC, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04,
               16'h0001, myMAC, myIP, 48'h0, tip};
    tx_bit  = (9'd41 - {3'b000, tx_addr}) << 3;
    tx_byte = frame[tx_bit +: 8];
  end

  always_comb begin
    rx_ref = '0;
    unique case (rx_addr)
      6'd12: rx_ref = 8'h08;  6'd13: rx_ref = 8'h06;
      6'd14: rx_ref = 8'h00;  6'd15: rx_ref = 8'h01;
      6'd16: rx_ref = 8'h08;  6'd17: rx_ref = 8'h00;
      6'd18: rx_ref = 8'h06;  6'd19: rx_ref = 8'h04;
      6'd20: rx_ref = 8'h00;  6'd21: rx_ref = 8'h02;
      6'd28: rx_ref = tip[31:24];  6'd29: rx_ref = tip[23:16];
      6'd30: rx_ref = tip[15:8];   6'd31: rx_ref = tip[7:0];
      6'd38: rx_ref = myIP[31:24]; 6'd39: rx_ref = myIP[23:16];
      6'd40: rx_ref = myIP[15:8];  6'd41: rx_ref = myIP[7:0];
      default: rx_ref = '0;
    endcase
  end

  // Scan order: header/oper, SPA, TPA, and finally the sender MAC.
  always_comb begin
    unique case (rx_addr)
      6'd21:   rx_next = 6'd28;
      6'd31:   rx_next = 6'd38;
      6'd41:   rx_next = 6'd22;
      default: rx_next = rx_addr + 6'd1;
    endcase
    capture  = (rx_addr >= 6'd22) && (rx_addr <= 6'd27);
    scan_end = capture ? (rx_addr == 6'd27) : (packet_data != rx_ref);
  end

  always_ff @(posedge mac_clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:       if (start) next_state = TX_WE;
      TX_WE:      next_state = TX_NEXT;
      TX_NEXT:    next_state = (tx_addr == 6'd41) ? TX_XMIT : TX_WE;
      TX_XMIT:    next_state = WAIT_REPLY;
      WAIT_REPLY: if (packet_ready) next_state = RX_SET;
                  else if (expired) next_state = RETRY;
      RX_SET:     next_state = RX_WAIT1;
      RX_WAIT1:   next_state = RX_WAIT2;
      RX_WAIT2:   next_state = RX_CHECK;
      RX_CHECK:   next_state = scan_end ? RX_DONE : RX_SET;
      RX_DONE:    next_state = RX_RELEASE;
      RX_RELEASE: if (!packet_ready)
                    next_state = match ? RESOLVE : (expired ? RETRY : WAIT_REPLY);
      RETRY:      next_state = more_tries ? TX_WE : FAILED;
      RESOLVE:    next_state = IDLE;
      FAILED:     next_state = IDLE;
      default:    next_state = IDLE;
    endcase
  end

  always_ff @(posedge mac_clk) begin
    if (reset) begin
      tip     <= '0;
      attempt <= '0;
      cnt     <= '0;
      tx_addr <= '0;
      rx_addr <= '0;
      shadow  <= '0;
      mac_q   <= '0;
      match   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          tip     <= target_ip;
          attempt <= '0;
          tx_addr <= '0;
        end
        TX_NEXT: if (tx_addr != 6'd41) tx_addr <= tx_addr + 6'd1;
        TX_XMIT: cnt <= '0;
        WAIT_REPLY: if (packet_ready) begin
          rx_addr <= 6'd12;
          match   <= 1'b0;
        end
        RX_CHECK: begin
          if (capture) shadow <= {shadow[39:0], packet_data};
          if (capture && rx_addr == 6'd27) match <= 1'b1;
          if (!scan_end) rx_addr <= rx_next;
        end
        RX_RELEASE: if (!packet_ready && match) mac_q <= shadow;
        RETRY: if (more_tries) begin
          attempt <= attempt + AW'(1);
          tx_addr <= '0;
        end
        default: ;
      endcase
      // Saturates at the last count so an expiry during a scan is still seen on release.
      if (counting && !expired) cnt <= cnt + CW'(1);
    end
  end

  always_comb begin
    busy             = (state != IDLE);
    packet_out_we    = (state == TX_WE);
    packet_out       = (state == TX_WE || state == TX_NEXT) ? tx_byte : '0;
    packet_out_addr  = tx_addr;
    packet_xmit      = (state == TX_XMIT);
    packet_read_addr = rx_addr;
    done_with_packet = (state == RX_DONE);
    resolved_valid   = (state == RESOLVE);
    resolved_mac     = mac_q;
    fail             = (state == FAILED);
  end

endmodule

// File: tb/tb_arp_requester.sv
// Directed bench for arp_requester: TX frame table, RX reply table, timeout/retry,
// reset abort and idle/busy input handling.
module tb_arp_requester;

  logic        mac_clk = 1'b0;
  logic        reset, start, packet_ready, to_start, to_ready;
  logic [31:0] target_ip, my_ip;
  logic [47:0] my_mac;
  logic [7:0]  packet_data, to_data;

  logic        busy, resolved_valid, fail, done_with_packet, packet_out_we, packet_xmit;
  logic [47:0] resolved_mac;
  logic [5:0]  packet_read_addr, packet_out_addr;
  logic [7:0]  packet_out;

  logic        to_busy, to_valid, to_fail, to_done, to_we, to_xmit;
  logic [47:0] to_mac;
  logic [5:0]  to_rd_addr, to_out_addr;
  logic [7:0]  to_out;

  always #5 mac_clk = ~mac_clk;

  arp_requester dut (
    .mac_clk(mac_clk), .reset(reset), .start(start), .target_ip(target_ip),
    .myMAC(my_mac), .myIP(my_ip), .busy(busy), .resolved_mac(resolved_mac),
    .resolved_valid(resolved_valid), .fail(fail), .packet_ready(packet_ready),
    .packet_read_addr(packet_read_addr), .packet_data(packet_data),
    .done_with_packet(done_with_packet), .packet_out(packet_out),
    .packet_out_addr(packet_out_addr), .packet_out_we(packet_out_we),
    .packet_xmit(packet_xmit)
  );

  arp_requester #(.TIMEOUT_CYCLES(100), .MAX_RETRIES(2)) dut_to (
    .mac_clk(mac_clk), .reset(reset), .start(to_start), .target_ip(target_ip),
    .myMAC(my_mac), .myIP(my_ip), .busy(to_busy), .resolved_mac(to_mac),
    .resolved_valid(to_valid), .fail(to_fail), .packet_ready(to_ready),
    .packet_read_addr(to_rd_addr), .packet_data(to_data),
    .done_with_packet(to_done), .packet_out(to_out),
    .packet_out_addr(to_out_addr), .packet_out_we(to_we),
    .packet_xmit(to_xmit)
  );

  // RX buffer: data appears two cycles after the read address changes.
  logic [7:0] rx_mem [64];
  logic [7:0] rx_d1;
  always @(posedge mac_clk) begin
    rx_d1       <= rx_mem[packet_read_addr];
    packet_data <= rx_d1;
  end

  logic [7:0] tx_mem [64];
  int xmit_cnt = 0, done_cnt = 0, rv_cnt = 0, fail_cnt = 0, wr_cnt = 0, rd_chg = 0;
  int to_xmit_cnt = 0, to_fail_cnt = 0, cyc = 0;
  int to_xmit_cyc [8];
  logic [5:0] rd_prev = '0;

  always @(negedge mac_clk) begin
    cyc <= cyc + 1;
    if (packet_xmit)      xmit_cnt <= xmit_cnt + 1;
    if (done_with_packet) done_cnt <= done_cnt + 1;
    if (resolved_valid)   rv_cnt   <= rv_cnt + 1;
    if (fail)             fail_cnt <= fail_cnt + 1;
    if (packet_out_we) begin
      tx_mem[packet_out_addr] <= packet_out;
      wr_cnt <= wr_cnt + 1;
    end
    if (packet_read_addr != rd_prev) rd_chg <= rd_chg + 1;
    rd_prev <= packet_read_addr;
    if (to_xmit) begin
      if (to_xmit_cnt < 8) to_xmit_cyc[to_xmit_cnt] <= cyc;
      to_xmit_cnt <= to_xmit_cnt + 1;
    end
    if (to_fail) to_fail_cnt <= to_fail_cnt + 1;
  end

  typedef struct { logic [5:0] addr; logic [7:0] data; } txv_t;
  typedef struct {
    logic        do_start;
    logic [15:0] oper;
    logic [47:0] sha;
    logic [31:0] spa;
    logic [31:0] tpa;
    logic        exp_valid;
    logic [47:0] exp_mac;
    logic        exp_busy;
  } rxv_t;

  txv_t         tx_tab [42];
  rxv_t         rx_tab [4];
  logic [335:0] frame_exp;
  int           n_checks = 0, n_fail = 0;
  int           x0, w0, d0, v0, f0, r0, gap;
  logic         found;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge mac_clk);
      #1;
    end
  endtask

  task automatic pulse_start(input logic [31:0] ip);
    target_ip = ip;
    start     = 1'b1;
    step(1);
    start     = 1'b0;
  endtask

  task automatic wait_xmit(input string name, input int bound);
    int base;
    base  = xmit_cnt;
    found = 1'b0;
    for (int i = 0; i < bound && !found; i++) begin
      step(1);
      if (xmit_cnt != base) found = 1'b1;
    end
    check(name, found, 1'b1);
  endtask

  task automatic check_frame(input string tag);
    for (int i = 0; i < 42; i++)
      check($sformatf("%s byte %0d", tag, i), tx_mem[tx_tab[i].addr], tx_tab[i].data);
  endtask

  task automatic load_pkt(input logic [15:0] oper, input logic [47:0] sha,
                          input logic [31:0] spa, input logic [31:0] tpa);
    logic [335:0] p;
    p = {my_mac, sha, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04, oper, sha, spa,
         my_mac, tpa};
    for (int i = 0; i < 64; i++) rx_mem[i] = (i < 42) ? p[8*(41-i) +: 8] : 8'h00;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; packet_ready = 1'b0;
    to_start = 1'b0; to_ready = 1'b0; to_data = 8'h00;
    target_ip = 32'hC0A8000A;
    my_mac = 48'h001122334455;
    my_ip  = 32'hC0A80002;
    frame_exp = 336'hFFFFFFFFFFFF_001122334455_0806_0001_0800_06_04_0001_001122334455_C0A80002_000000000000_C0A8000A;
    for (int i = 0; i < 42; i++) begin
      tx_tab[i].addr = 6'(i);
      tx_tab[i].data = frame_exp[8*(41-i) +: 8];
    end
    rx_tab[0] = '{1'b0, 16'h0002, 48'hAABBCCDDEEFF, 32'hC0A8000A, 32'hC0A80002,
                  1'b1, 48'hAABBCCDDEEFF, 1'b0};
    rx_tab[1] = '{1'b1, 16'h0002, 48'h0A0B0C0D0E0F, 32'hC0A8000B, 32'hC0A80002,
                  1'b0, 48'hAABBCCDDEEFF, 1'b1};
    rx_tab[2] = '{1'b0, 16'h0001, 48'h0A0B0C0D0E0F, 32'hC0A8000A, 32'hC0A80002,
                  1'b0, 48'hAABBCCDDEEFF, 1'b1};
    rx_tab[3] = '{1'b0, 16'h0002, 48'h112233445566, 32'hC0A8000A, 32'hC0A80002,
                  1'b1, 48'h112233445566, 1'b0};
    load_pkt(16'h0002, 48'hAABBCCDDEEFF, 32'hC0A8000A, 32'hC0A80002);
    step(3);
    check("reset strobes/addrs",
          {busy, resolved_valid, fail, done_with_packet, packet_out_we, packet_xmit,
           packet_out, packet_out_addr, packet_read_addr}, 64'h0);
    check("reset resolved_mac", resolved_mac, 48'h0);
    reset = 1'b0;
    step(2);

    // Packet offered while idle must be left alone.
    d0 = done_cnt; r0 = rd_chg;
    packet_ready = 1'b1;
    step(20);
    check("idle no done", done_cnt - d0, 0);
    check("idle no reads", rd_chg - r0, 0);
    check("idle busy", busy, 1'b0);
    packet_ready = 1'b0;
    step(2);

    // First request; a second start and a target_ip change mid-frame are ignored.
    x0 = xmit_cnt; w0 = wr_cnt;
    pulse_start(32'hC0A8000A);
    check("busy after start", busy, 1'b1);
    step(9);
    target_ip = 32'h01020304;
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_xmit("T1 xmit seen", 200);
    step(5);
    check("T1 xmit count", xmit_cnt - x0, 1);
    check("T1 write count", wr_cnt - w0, 42);
    check("T1 busy", busy, 1'b1);
    check_frame("T1");

    for (int e = 0; e < 4; e++) begin
      if (rx_tab[e].do_start) begin
        pulse_start(32'hC0A8000A);
        wait_xmit($sformatf("rx%0d xmit seen", e), 200);
      end
      load_pkt(rx_tab[e].oper, rx_tab[e].sha, rx_tab[e].spa, rx_tab[e].tpa);
      d0 = done_cnt; v0 = rv_cnt;
      packet_ready = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 400 && !found; i++) begin
        step(1);
        if (done_cnt != d0) found = 1'b1;
      end
      check($sformatf("rx%0d done seen", e), found, 1'b1);
      step(3);
      check($sformatf("rx%0d no result before release", e), rv_cnt - v0, 0);
      packet_ready = 1'b0;
      step(4);
      check($sformatf("rx%0d done count", e), done_cnt - d0, 1);
      check($sformatf("rx%0d valid count", e), rv_cnt - v0, int'(rx_tab[e].exp_valid));
      check($sformatf("rx%0d resolved_mac", e), resolved_mac, rx_tab[e].exp_mac);
      check($sformatf("rx%0d busy", e), busy, rx_tab[e].exp_busy);
    end

    // Timeout instance: three attempts, then fail.
    x0 = to_xmit_cnt; f0 = to_fail_cnt;
    to_start = 1'b1;
    step(1);
    to_start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 1500 && !found; i++) begin
      step(1);
      if (to_fail_cnt != f0) found = 1'b1;
    end
    check("T4 fail seen", found, 1'b1);
    step(3);
    check("T4 xmit count", to_xmit_cnt - x0, 3);
    check("T4 fail count", to_fail_cnt - f0, 1);
    check("T4 busy", to_busy, 1'b0);
    for (int k = 1; k < 3; k++) begin
      gap = to_xmit_cyc[x0 + k] - to_xmit_cyc[x0 + k - 1];
      check_range($sformatf("T4 gap %0d", k), gap, 184, 188);
    end

    // Reset in the middle of the TX frame.
    x0 = xmit_cnt;
    pulse_start(32'hC0A8000A);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (packet_out_we && packet_out_addr == 6'd20) found = 1'b1;
      else step(1);
    end
    check("T5 reached addr 20", found, 1'b1);
    reset = 1'b1;
    step(1);
    check("T5 reset busy", busy, 1'b0);
    check("T5 reset tx outputs", {packet_out_we, packet_xmit, packet_out, packet_out_addr}, 64'h0);
    check("T5 reset resolved_mac", resolved_mac, 48'h0);
    reset = 1'b0;
    step(10);
    check("T5 no xmit after abort", xmit_cnt - x0, 0);
    x0 = xmit_cnt; w0 = wr_cnt;
    pulse_start(32'hC0A8000A);
    wait_xmit("T5 xmit seen", 200);
    step(2);
    check("T5 write count", wr_cnt - w0, 42);
    check("T5 xmit count", xmit_cnt - x0, 1);
    check_frame("T5");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
